idex_imm_stage: RTL and testbench
=================================

Name: idex_imm_stage

Overview:
- ID/EX pipeline stage directly downstream of the immediate sign extender.
- Captures the extended immediate, applies the instruction's immediate shaping (pass, <<2 branch offset, <<16 LUI, zero), and registers it with rs/rt data, destination register and control bits.
- Decouples decode from execute with a valid/ready handshake backed by a 2-entry skid buffer, plus stall (en_n) and flush.

Parameters:
- DATA_WIDTH, 32, width of immediate, register data and PC.
- REG_ADDR_WIDTH, 5, destination register index width.
- CTRL_WIDTH, 12, opaque execute/mem/wb control bundle width.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- en_n  in  1  active-low stage enable; 1 = stall/hold.
- flush  in  1  synchronous kill of all held entries.
- in_valid  in  1  upstream entry valid.
- in_ready  out  1  stage can accept this cycle.
- imm_ext  in  DATA_WIDTH  extended immediate from sign extender.
- imm_sel  in  2  00 pass, 01 shl2, 10 shl16, 11 zero.
- rs_data  in  DATA_WIDTH  register file port A.
- rt_data  in  DATA_WIDTH  register file port B.
- dest_reg  in  REG_ADDR_WIDTH  writeback register.
- ctrl_in  in  CTRL_WIDTH  control bundle.
- pc4_in  in  DATA_WIDTH  PC+4 of instruction.
- out_valid  out  1  entry presented to EX.
- out_ready  in  1  EX accepts entry.
- imm_out, rs_out, rt_out, pc4_out  out  DATA_WIDTH  registered fields.
- dest_out  out  REG_ADDR_WIDTH, ctrl_out  out  CTRL_WIDTH.
- br_target  out  DATA_WIDTH  only with the optional feature.

Behaviour:
- Shaping happens before capture and is combinational:
  - pass: imm_ext.
  - shl2: {imm_ext[DATA_WIDTH-3:0], 2'b00}.
  - shl16: {imm_ext[15:0], 16'h0}.
  - zero: all zeros.
  - Results are truncated to DATA_WIDTH with no overflow flag.
- Storage: main register (drives outputs) and skid register, each with its own valid bit.
- Accept condition: in_valid & in_ready.
- in_ready = !skid_valid & !en_n. It is derived from registered state and en_n, never from out_ready.
- Visible output: out_valid = main_valid & !en_n. Outputs show main register contents.
- Transfer out: out_valid & out_ready.
- Cases per cycle when en_n=0 and flush=0:
  - Transfer and no accept: main takes skid if skid_valid (skid clears), else main_valid clears.
  - Accept and main empty, or accept with simultaneous transfer and skid empty: new entry loads into main.
  - Accept while main is full and not transferring: new entry goes to skid; in_ready drops next cycle.
  - Skid full: in_ready=0 and no accept. Transfer moves skid to main.
- Latency: 1 cycle from accept to out_valid when main is empty. Throughput is 1/cycle at steady state.
- en_n=1: no state change, in_ready=0, out_valid=0. Data registers hold.
- flush=1: both valids clear next edge. Flush has priority over en_n and over a same-cycle accept. Data registers don't care.
- Reset (any time, including mid-transfer): both valids 0, all data registers 0, so every output reads 0 and in_ready=1 once rst deasserts (if en_n=0).
- No combinational path from out_ready to in_ready.

Optional Feature:
- Macro: IDEX_BRANCH_TARGET_EN.
- Defined: br_target = pc4_out + imm_out, registered alongside the entry (computed at capture from pc4_in and shaped immediate), modulo 2^DATA_WIDTH, reset 0.
- Undefined: br_target port and adder are absent.

Decomposition:
- Shared package/include: imm_sel encodings (IMM_PASS=2'b00, IMM_SHL2, IMM_SHL16, IMM_ZERO) and default widths.
- One natural sub-module: idex_entry_reg, a single register slot with load/valid/clear, instantiated twice (main, skid).
- Immediate shaping stays inline.

Test Plan:
- Reset: drive rst=0 mid-stream with 2 entries held -> out_valid=0, imm_out=0, in_ready=1 after release.
- Shaping: imm_ext=32'hFFFF_FFFC with sel=01 -> imm_out=32'hFFFF_FFF0. sel=10 with imm_ext=32'h0000_1234 -> 32'h1234_0000. sel=11 -> 0.
- Backpressure: out_ready=0, push A,B -> in_ready=0 after B. Raise out_ready -> A then B emerge in order, no loss or duplication.
- Stall: en_n=1 for 3 cycles with A held -> out_valid=0, in_ready=0. Release -> A presented unchanged.
- Flush with simultaneous in_valid=1 and a full skid -> next cycle out_valid=0, in_ready=1, dropped entry never appears.
- IDEX_BRANCH_TARGET_EN: pc4_in=32'h0040_0010, imm_ext=32'hFFFF_FFFF, sel=01 -> br_target=32'h0040_000C.

Source files
------------

// File: rtl/idex_imm_stage_pkg.sv
// Shared definitions for the ID/EX immediate stage: imm_sel encodings and default widths.
package idex_imm_stage_pkg;

    localparam int DEF_DATA_WIDTH     = 32;
    localparam int DEF_REG_ADDR_WIDTH = 5;
    localparam int DEF_CTRL_WIDTH     = 12;

    typedef enum logic [1:0] {
        IMM_PASS  = 2'b00,
        IMM_SHL2  = 2'b01,
        IMM_SHL16 = 2'b10,
        IMM_ZERO  = 2'b11
    } imm_sel_e;

endpackage

// File: rtl/idex_entry_reg.sv
// One register slot of the ID/EX stage: a payload register plus its valid bit.
// Clear wins over load; payload only changes on load.
module idex_entry_reg
    import idex_imm_stage_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         clr,
    input  logic [W-1:0] data_in,
    output logic         valid,
    output logic [W-1:0] data
);

    logic         valid_d, valid_q;
    logic [W-1:0] data_d, data_q;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (clr) begin
            valid_d = 1'b0;
        end else if (load) begin
            valid_d = 1'b1;
        end
        if (load) begin
            data_d = data_in;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid = valid_q;
    assign data  = data_q;

endmodule

// File: rtl/idex_imm_stage.sv
// ID/EX stage: shapes the extended immediate and registers it with operands and control
// behind a valid/ready handshake with a skid slot. Optional macro: IDEX_BRANCH_TARGET_EN.
module idex_imm_stage
    import idex_imm_stage_pkg::*;
#(
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int REG_ADDR_WIDTH = DEF_REG_ADDR_WIDTH,
    parameter int CTRL_WIDTH     = DEF_CTRL_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en_n,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_WIDTH-1:0]     imm_ext,
    input  logic [1:0]                imm_sel,
    input  logic [DATA_WIDTH-1:0]     rs_data,
    input  logic [DATA_WIDTH-1:0]     rt_data,
    input  logic [REG_ADDR_WIDTH-1:0] dest_reg,
    input  logic [CTRL_WIDTH-1:0]     ctrl_in,
    input  logic [DATA_WIDTH-1:0]     pc4_in,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_WIDTH-1:0]     imm_out,
    output logic [DATA_WIDTH-1:0]     rs_out,
    output logic [DATA_WIDTH-1:0]     rt_out,
    output logic [DATA_WIDTH-1:0]     pc4_out,
    output logic [REG_ADDR_WIDTH-1:0] dest_out,
`ifdef IDEX_BRANCH_TARGET_EN
    output logic [DATA_WIDTH-1:0]     br_target,
`endif
    output logic [CTRL_WIDTH-1:0]     ctrl_out
);

`ifdef IDEX_BRANCH_TARGET_EN
    localparam int PW = 5 * DATA_WIDTH + REG_ADDR_WIDTH + CTRL_WIDTH;
`else
    localparam int PW = 4 * DATA_WIDTH + REG_ADDR_WIDTH + CTRL_WIDTH;
`endif

    logic [DATA_WIDTH-1:0] imm_shaped;
    logic [PW-1:0]         in_payload, main_data_in, main_data, skid_data;
    logic                  main_valid, skid_valid;
    logic                  accept, xfer;
    logic                  main_load, main_clr, main_from_skid, skid_load, skid_clr;

    always_comb begin
        imm_shaped = '0;
        case (imm_sel_e'(imm_sel))
            IMM_PASS:  imm_shaped = imm_ext;
            IMM_SHL2:  imm_shaped = imm_ext << 2;
            IMM_SHL16: imm_shaped = imm_ext << 16;
            default:   imm_shaped = '0;
        endcase
    end

`ifdef IDEX_BRANCH_TARGET_EN
    logic [DATA_WIDTH-1:0] br_next;
    assign br_next    = pc4_in + imm_shaped;
    assign in_payload = {imm_shaped, rs_data, rt_data, pc4_in, dest_reg, ctrl_in, br_next};
    assign {imm_out, rs_out, rt_out, pc4_out, dest_out, ctrl_out, br_target} = main_data;
`else
    assign in_payload = {imm_shaped, rs_data, rt_data, pc4_in, dest_reg, ctrl_in};
    assign {imm_out, rs_out, rt_out, pc4_out, dest_out, ctrl_out} = main_data;
`endif

    // Ready depends only on registered state and en_n, never on out_ready.
    assign in_ready  = !skid_valid && !en_n;
    assign out_valid = main_valid && !en_n;
    assign accept    = in_valid && in_ready;
    assign xfer      = out_valid && out_ready;

    always_comb begin
        main_load      = 1'b0;
        main_clr       = 1'b0;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;
        skid_clr       = 1'b0;
        if (flush) begin
            main_clr = 1'b1;
            skid_clr = 1'b1;
        end else if (xfer) begin
            if (skid_valid) begin
                main_load      = 1'b1;
                main_from_skid = 1'b1;
                skid_clr       = 1'b1;
            end else if (accept) begin
                main_load = 1'b1;
            end else begin
                main_clr = 1'b1;
            end
        end else if (accept) begin
            if (main_valid) begin
                skid_load = 1'b1;
            end else begin
                main_load = 1'b1;
            end
        end
    end

    assign main_data_in = main_from_skid ? skid_data : in_payload;

    idex_entry_reg #(.W(PW)) u_main (
        .clk     (clk),
        .rst     (rst),
        .load    (main_load),
        .clr     (main_clr),
        .data_in (main_data_in),
        .valid   (main_valid),
        .data    (main_data)
    );

    idex_entry_reg #(.W(PW)) u_skid (
        .clk     (clk),
        .rst     (rst),
        .load    (skid_load),
        .clr     (skid_clr),
        .data_in (in_payload),
        .valid   (skid_valid),
        .data    (skid_data)
    );

endmodule

// File: tb/tb_idex_imm_stage.sv
// Directed bench for idex_imm_stage: reset, shaping, backpressure, stall, flush, branch target.
module tb_idex_imm_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        en_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] imm_ext;
    logic [1:0]  imm_sel;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [4:0]  dest_reg;
    logic [11:0] ctrl_in;
    logic [31:0] pc4_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] imm_out;
    logic [31:0] rs_out;
    logic [31:0] rt_out;
    logic [31:0] pc4_out;
    logic [4:0]  dest_out;
    logic [11:0] ctrl_out;
`ifdef IDEX_BRANCH_TARGET_EN
    logic [31:0] br_target;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    idex_imm_stage dut (
        .clk       (clk),
        .rst       (rst),
        .en_n      (en_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .imm_ext   (imm_ext),
        .imm_sel   (imm_sel),
        .rs_data   (rs_data),
        .rt_data   (rt_data),
        .dest_reg  (dest_reg),
        .ctrl_in   (ctrl_in),
        .pc4_in    (pc4_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .imm_out   (imm_out),
        .rs_out    (rs_out),
        .rt_out    (rt_out),
        .pc4_out   (pc4_out),
        .dest_out  (dest_out),
`ifdef IDEX_BRANCH_TARGET_EN
        .br_target (br_target),
`endif
        .ctrl_out  (ctrl_out)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
        $display("check %-22s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one input entry; the other fields are derived from rs so order can be traced.
    task automatic set_in(input logic v, input logic [31:0] imm, input logic [1:0] sel,
                          input logic [31:0] rs);
        in_valid = v;
        imm_ext  = imm;
        imm_sel  = sel;
        rs_data  = rs;
        rt_data  = ~rs;
        pc4_in   = rs + 32'd4;
        dest_reg = rs[4:0];
        ctrl_in  = rs[11:0];
    endtask

    initial begin
        rst       = 1'b0;
        en_n      = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        set_in(1'b0, 32'h0, 2'b00, 32'h0);
        tick();
        tick();
        rst = 1'b1;
        #1;
        check("reset_out_valid", {31'b0, out_valid}, 32'd0);
        check("reset_in_ready", {31'b0, in_ready}, 32'd1);
        check("reset_imm_out", imm_out, 32'd0);
        check("reset_rs_out", rs_out, 32'd0);
        check("reset_ctrl_out", {20'b0, ctrl_out}, 32'd0);

        // Shaping, streaming one entry per cycle
        out_ready = 1'b1;
        set_in(1'b1, 32'hFFFF_FFFC, 2'b01, 32'h0000_0011);
        tick();
        check("shl2_valid", {31'b0, out_valid}, 32'd1);
        check("shl2_imm", imm_out, 32'hFFFF_FFF0);
        set_in(1'b1, 32'h0000_1234, 2'b10, 32'h0000_0022);
        tick();
        check("shl16_imm", imm_out, 32'h1234_0000);
        check("shl16_rs", rs_out, 32'h0000_0022);
        set_in(1'b1, 32'h0000_0005, 2'b11, 32'h0000_0033);
        tick();
        check("zero_imm", imm_out, 32'h0);
        set_in(1'b1, 32'hABCD_1234, 2'b00, 32'h0000_0044);
        tick();
        check("pass_imm", imm_out, 32'hABCD_1234);
        check("pass_rt", rt_out, 32'hFFFF_FFBB);
        check("pass_pc4", pc4_out, 32'h0000_0048);
        check("pass_dest", {27'b0, dest_out}, 32'h0000_0004);
        set_in(1'b0, 32'h0, 2'b00, 32'h0);
        tick();
        check("drain_out_valid", {31'b0, out_valid}, 32'd0);

        // Backpressure: A then B with out_ready low
        out_ready = 1'b0;
        set_in(1'b1, 32'h0000_0100, 2'b00, 32'h0000_00A1);
        tick();
        check("bp_a_valid", {31'b0, out_valid}, 32'd1);
        check("bp_ready_after_a", {31'b0, in_ready}, 32'd1);
        set_in(1'b1, 32'h0000_0200, 2'b00, 32'h0000_00B2);
        tick();
        check("bp_ready_after_b", {31'b0, in_ready}, 32'd0);
        check("bp_holds_a", rs_out, 32'h0000_00A1);
        set_in(1'b0, 32'h0, 2'b00, 32'h0);
        tick();
        check("bp_still_a", rs_out, 32'h0000_00A1);
        out_ready = 1'b1;
        tick();
        check("bp_b_valid", {31'b0, out_valid}, 32'd1);
        check("bp_b_rs", rs_out, 32'h0000_00B2);
        check("bp_b_imm", imm_out, 32'h0000_0200);
        check("bp_ready_again", {31'b0, in_ready}, 32'd1);
        tick();
        check("bp_empty", {31'b0, out_valid}, 32'd0);

        // Stall with A held; an offered entry during the stall must not be taken
        out_ready = 1'b0;
        set_in(1'b1, 32'h0000_0555, 2'b00, 32'h0000_5555);
        tick();
        en_n      = 1'b1;
        out_ready = 1'b1;
        set_in(1'b1, 32'h0000_0666, 2'b00, 32'h0000_6666);
        for (int i = 0; i < 3; i++) begin
            #1;
            check("stall_out_valid", {31'b0, out_valid}, 32'd0);
            check("stall_in_ready", {31'b0, in_ready}, 32'd0);
            tick();
        end
        set_in(1'b0, 32'h0, 2'b00, 32'h0);
        out_ready = 1'b0;
        en_n      = 1'b0;
        #1;
        check("stall_release_valid", {31'b0, out_valid}, 32'd1);
        check("stall_release_rs", rs_out, 32'h0000_5555);
        check("stall_release_imm", imm_out, 32'h0000_0555);
        check("stall_ready_empty_skid", {31'b0, in_ready}, 32'd1);
        out_ready = 1'b1;
        tick();
        check("stall_drained", {31'b0, out_valid}, 32'd0);

        // Flush with a full skid and an offered entry
        out_ready = 1'b0;
        set_in(1'b1, 32'h1, 2'b00, 32'h0000_0C01);
        tick();
        set_in(1'b1, 32'h2, 2'b00, 32'h0000_0C02);
        tick();
        check("flush_skid_full", {31'b0, in_ready}, 32'd0);
        set_in(1'b1, 32'h3, 2'b00, 32'h0000_0C03);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        set_in(1'b0, 32'h0, 2'b00, 32'h0);
        check("flush_out_valid", {31'b0, out_valid}, 32'd0);
        check("flush_in_ready", {31'b0, in_ready}, 32'd1);
        out_ready = 1'b1;
        tick();
        check("flush_nothing_later", {31'b0, out_valid}, 32'd0);

        // Flush beats a same-cycle accept
        out_ready = 1'b0;
        set_in(1'b1, 32'h4, 2'b00, 32'h0000_0C04);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        set_in(1'b0, 32'h0, 2'b00, 32'h0);
        check("flush_vs_accept", {31'b0, out_valid}, 32'd0);

        // Asynchronous reset with two entries held
        set_in(1'b1, 32'h7, 2'b00, 32'h0000_0D01);
        tick();
        set_in(1'b1, 32'h8, 2'b00, 32'h0000_0D02);
        tick();
        set_in(1'b0, 32'h0, 2'b00, 32'h0);
        check("prereset_full", {31'b0, in_ready}, 32'd0);
        rst = 1'b0;
        #1;
        check("async_rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("async_rst_imm", imm_out, 32'd0);
        check("async_rst_rs", rs_out, 32'd0);
        tick();
        rst = 1'b1;
        #1;
        check("post_rst_in_ready", {31'b0, in_ready}, 32'd1);
        check("post_rst_out_valid", {31'b0, out_valid}, 32'd0);

`ifdef IDEX_BRANCH_TARGET_EN
        out_ready = 1'b1;
        set_in(1'b1, 32'hFFFF_FFFF, 2'b01, 32'h0000_00E1);
        pc4_in = 32'h0040_0010;
        tick();
        set_in(1'b0, 32'h0, 2'b00, 32'h0);
        check("br_target", br_target, 32'h0040_000C);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
